// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two asynchronous read ports,
// one write port and a per-register pending scoreboard for RAW hazard stalls.
// All state updates on the falling edge of clock; reset is synchronous, active-high.
// Optional feature macro REGFILE_BYPASS_EN: forwards same-cycle writeback data
// and clears busy on the read ports before the edge.

module regfile_sb #(
    parameter int DW      = 16,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] adr_a,
    input  logic [AW-1:0] adr_b,
    output logic [DW-1:0] Dout1,
    output logic [DW-1:0] Dout2,
    input  logic          RegWrite,
    input  logic [AW-1:0] adr_w,
    input  logic [DW-1:0] Din,
    input  logic          iss_en,
    input  logic [AW-1:0] adr_i,
    output logic          busy_a,
    output logic          busy_b,
    output logic          hazard,
    output logic [AW:0]   pend_cnt
);

    localparam int   DEPTH   = 1 << AW;
    localparam logic ZERO_EN = (ZERO_R0 != 0);

    logic [DW-1:0]    mem_r [DEPTH];
    logic [DEPTH-1:0] pend_r;
    logic [AW:0]      pend_cnt_r;

    logic [DEPTH-1:0] pend_nxt_s;
    logic             wr_ok_s;
    logic             iss_ok_s;
    logic [DW-1:0]    rd_a_s;
    logic [DW-1:0]    rd_b_s;
    logic             bsy_a_s;
    logic             bsy_b_s;
    logic             zero_a_s;
    logic             zero_b_s;

    // Number of set bits in a pending vector.
    function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
        logic [AW:0] c;
        c = {(AW+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // With ZERO_R0, writes and issues aimed at address 0 are dropped here.
    assign wr_ok_s  = RegWrite && !(ZERO_EN && (adr_w == {AW{1'b0}}));
    assign iss_ok_s = iss_en   && !(ZERO_EN && (adr_i == {AW{1'b0}}));
    assign zero_a_s = ZERO_EN && (adr_a == {AW{1'b0}});
    assign zero_b_s = ZERO_EN && (adr_b == {AW{1'b0}});

    // Next pending vector: an issue beats a writeback to the same register.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int i = 0; i < DEPTH; i++) begin
            pend_nxt_s[i] = (iss_ok_s && (adr_i == AW'(i))) ? 1'b1 :
                            (wr_ok_s  && (adr_w == AW'(i))) ? 1'b0 : pend_r[i];
        end
    end

    // Register array, scoreboard and pending count, updated on the falling edge.
    always_ff @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            pend_r     <= {DEPTH{1'b0}};
            pend_cnt_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                mem_r[adr_w] <= Din;
            end
            pend_r     <= pend_nxt_s;
            pend_cnt_r <= popcount(pend_nxt_s);
        end
    end

    // Read ports and busy lookup, with optional same-cycle writeback forwarding.
    always_comb begin
        rd_a_s  = mem_r[adr_a];
        rd_b_s  = mem_r[adr_b];
        bsy_a_s = pend_r[adr_a];
        bsy_b_s = pend_r[adr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok_s && (adr_w == adr_a)) begin
            rd_a_s  = Din;
            bsy_a_s = 1'b0;
        end else begin
            rd_a_s  = mem_r[adr_a];
            bsy_a_s = pend_r[adr_a];
        end
        if (wr_ok_s && (adr_w == adr_b)) begin
            rd_b_s  = Din;
            bsy_b_s = 1'b0;
        end else begin
            rd_b_s  = mem_r[adr_b];
            bsy_b_s = pend_r[adr_b];
        end
`endif
    end

    assign Dout1    = zero_a_s ? {DW{1'b0}} : rd_a_s;
    assign Dout2    = zero_b_s ? {DW{1'b0}} : rd_b_s;
    assign busy_a   = zero_a_s ? 1'b0 : bsy_a_s;
    assign busy_b   = zero_b_s ? 1'b0 : bsy_b_s;
    assign hazard   = busy_a | busy_b;
    assign pend_cnt = pend_cnt_r;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: two instances (ZERO_R0 = 0 and 1) share stimulus.
// Vector table + hand sequences for the listed corner cases, then random
// stimulus against an array-based reference model. Honours REGFILE_BYPASS_EN.

module tb_regfile_sb;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] adr_a, adr_b, adr_w, adr_i;
    logic          RegWrite, iss_en;
    logic [DW-1:0] Din;

    logic [DW-1:0] d1_0, d2_0, d1_1, d2_1;
    logic          ba0, bb0, hz0, ba1, bb1, hz1;
    logic [AW:0]   pc0, pc1;

    always #5 clock = ~clock;

    regfile_sb #(.DW(DW), .AW(AW), .ZERO_R0(0)) u_dut0 (
        .clock(clock), .reset(reset), .adr_a(adr_a), .adr_b(adr_b),
        .Dout1(d1_0), .Dout2(d2_0), .RegWrite(RegWrite), .adr_w(adr_w),
        .Din(Din), .iss_en(iss_en), .adr_i(adr_i), .busy_a(ba0),
        .busy_b(bb0), .hazard(hz0), .pend_cnt(pc0)
    );

    regfile_sb #(.DW(DW), .AW(AW), .ZERO_R0(1)) u_dut1 (
        .clock(clock), .reset(reset), .adr_a(adr_a), .adr_b(adr_b),
        .Dout1(d1_1), .Dout2(d2_1), .RegWrite(RegWrite), .adr_w(adr_w),
        .Din(Din), .iss_en(iss_en), .adr_i(adr_i), .busy_a(ba1),
        .busy_b(bb1), .hazard(hz1), .pend_cnt(pc1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: index 0 -> ZERO_R0 = 0, index 1 -> ZERO_R0 = 1
    logic [DW-1:0] m_mem  [2][DEPTH];
    logic          m_pend [2][DEPTH];

    typedef struct {
        logic          rst;
        logic          we;
        logic [AW-1:0] aw;
        logic [DW-1:0] din;
        logic          iss;
        logic [AW-1:0] ai;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [DW-1:0] e_d1;
        logic          e_ba;
        logic          e_hz;
        logic [AW:0]   e_cnt;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_read(input int c, input logic [AW-1:0] adr,
                                       output logic [DW-1:0] d, output logic b);
        d = m_mem[c][adr];
        b = m_pend[c][adr];
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && adr_w == adr && !(c == 1 && adr_w == 3'd0)) begin
            d = Din;
            b = 1'b0;
        end
`endif
        if (c == 1 && adr == 3'd0) begin
            d = 16'h0000;
            b = 1'b0;
        end
    endfunction

    function automatic int model_cnt(input int c);
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_pend[c][i] ? 1 : 0;
        return n;
    endfunction

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[c][i]  = 16'h0000;
                    m_pend[c][i] = 1'b0;
                end
            end else begin
                if (RegWrite && !(c == 1 && adr_w == 3'd0)) begin
                    m_mem[c][adr_w]  = Din;
                    m_pend[c][adr_w] = 1'b0;
                end
                if (iss_en && !(c == 1 && adr_i == 3'd0)) m_pend[c][adr_i] = 1'b1;
            end
        end
    endtask

    task automatic check_live(input string tag);
        logic [DW-1:0] ea, eb;
        logic          xa, xb;
        for (int c = 0; c < 2; c++) begin
            model_read(c, adr_a, ea, xa);
            model_read(c, adr_b, eb, xb);
            chk({tag, "_dout1"}, 32'(c == 0 ? d1_0 : d1_1), 32'(ea));
            chk({tag, "_dout2"}, 32'(c == 0 ? d2_0 : d2_1), 32'(eb));
            chk({tag, "_busy_a"}, 32'(c == 0 ? ba0 : ba1), 32'(xa));
            chk({tag, "_busy_b"}, 32'(c == 0 ? bb0 : bb1), 32'(xb));
            chk({tag, "_hazard"}, 32'(c == 0 ? hz0 : hz1), 32'(xa | xb));
            chk({tag, "_pend_cnt"}, 32'(c == 0 ? pc0 : pc1), 32'(model_cnt(c)));
        end
    endtask

    task automatic tick();
        @(negedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        RegWrite = 1'b0;
        iss_en   = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd3, 3'd0, 16'h0000, 1'b1, 1'b1, 4'd1};
        tbl[1]  = '{1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd0, 16'hBEEF, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 1'b1, 3'd5, 16'h00AA, 1'b1, 3'd5, 3'd5, 3'd0, 16'h00AA, 1'b1, 1'b1, 4'd1};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd3, 16'h00AA, 1'b1, 1'b1, 4'd1};
        tbl[4]  = '{1'b0, 1'b1, 3'd2, 16'h0042, 1'b0, 3'd0, 3'd2, 3'd5, 16'h0042, 1'b0, 1'b1, 4'd1};
        tbl[5]  = '{1'b0, 1'b1, 3'd5, 16'h5555, 1'b0, 3'd0, 3'd5, 3'd2, 16'h5555, 1'b0, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 1'b1, 4'd1};
        tbl[7]  = '{1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0, 3'd0, 16'hFFFF, 1'b0, 1'b0, 4'd0};
        tbl[8]  = '{1'b1, 1'b1, 3'd6, 16'hABCD, 1'b1, 3'd6, 3'd6, 3'd3, 16'h0000, 1'b0, 1'b0, 4'd0};
        tbl[9]  = '{1'b0, 1'b1, 3'd6, 16'h1357, 1'b1, 3'd1, 3'd6, 3'd1, 16'h1357, 1'b0, 1'b1, 4'd1};
        tbl[10] = '{1'b0, 1'b1, 3'd1, 16'h2468, 1'b0, 3'd0, 3'd1, 3'd6, 16'h2468, 1'b0, 1'b0, 4'd0};

        reset = 1'b1; RegWrite = 1'b0; iss_en = 1'b0;
        adr_a = 3'd0; adr_b = 3'd0; adr_w = 3'd0; adr_i = 3'd0; Din = 16'h0000;
        tick();
        tick();
        idle();

        // Reset: fill r1..r7, leave some pending, then reset clears everything
        for (int i = 1; i < DEPTH; i++) begin
            RegWrite = 1'b1; adr_w = 3'(i); Din = 16'(16'h1111 * i);
            iss_en = 1'b1; adr_i = 3'(i - 1);
            tick();
        end
        idle();
        reset = 1'b1;
        tick();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            adr_a = 3'(i); adr_b = 3'(DEPTH - 1 - i);
            #1;
            chk("rst_dout1", 32'(d1_0), 32'h0);
            chk("rst_dout2", 32'(d2_0), 32'h0);
            chk("rst_hazard", 32'(hz0), 32'h0);
        end
        chk("rst_pend_cnt", 32'(pc0), 32'h0);

        // Table-driven vectors, each applied on one falling edge
        for (int k = 0; k < 11; k++) begin
            reset = tbl[k].rst; RegWrite = tbl[k].we; adr_w = tbl[k].aw; Din = tbl[k].din;
            iss_en = tbl[k].iss; adr_i = tbl[k].ai;
            tick();
            idle();
            adr_a = tbl[k].ra; adr_b = tbl[k].rb;
            #1;
            chk($sformatf("vec%0d_dout1", k), 32'(d1_0), 32'(tbl[k].e_d1));
            chk($sformatf("vec%0d_busy_a", k), 32'(ba0), 32'(tbl[k].e_ba));
            chk($sformatf("vec%0d_hazard", k), 32'(hz0), 32'(tbl[k].e_hz));
            chk($sformatf("vec%0d_pend_cnt", k), 32'(pc0), 32'(tbl[k].e_cnt));
        end

        // Issue all addresses, re-issue r2: count saturates at depth (no wrap)
        for (int i = 0; i < DEPTH; i++) begin
            iss_en = 1'b1; adr_i = 3'(i);
            tick();
            chk("fill_pend_cnt", 32'(pc0), 32'(i + 1));
        end
        adr_i = 3'd2;
        tick();
        chk("reissue_pend_cnt", 32'(pc0), 32'd8);
        chk("reissue_pend_cnt_z", 32'(pc1), 32'd7);
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            RegWrite = 1'b1; adr_w = 3'(i); Din = 16'(16'h0101 * i);
            tick();
            chk("drain_pend_cnt", 32'(pc0), 32'(DEPTH - 1 - i));
        end
        idle();

        // ZERO_R0: write and issue r0 on the same edge are both discarded
        RegWrite = 1'b1; adr_w = 3'd0; Din = 16'hFFFF; iss_en = 1'b1; adr_i = 3'd0;
        tick();
        idle();
        adr_a = 3'd0; adr_b = 3'd0;
        #1;
        chk("z_dout1", 32'(d1_1), 32'h0);
        chk("z_busy_a", 32'(ba1), 32'h0);
        chk("z_pend_cnt", 32'(pc1), 32'h0);
        chk("nz_dout1", 32'(d1_0), 32'hFFFF);
        chk("nz_busy_a", 32'(ba0), 32'h1);
        chk("nz_pend_cnt", 32'(pc0), 32'h1);
        RegWrite = 1'b1; adr_w = 3'd0; Din = 16'h0000;
        tick();
        idle();

        // Same-cycle read of a register being written back while pending
        iss_en = 1'b1; adr_i = 3'd4;
        tick();
        idle();
        RegWrite = 1'b1; adr_w = 3'd4; Din = 16'h1234; adr_a = 3'd4; adr_b = 3'd1;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_dout1", 32'(d1_0), 32'h1234);
        chk("byp_busy_a", 32'(ba0), 32'h0);
`else
        chk("nobyp_dout1", 32'(d1_0), 32'h0404);
        chk("nobyp_busy_a", 32'(ba0), 32'h1);
`endif
        tick();
        idle();
        #1;
        chk("post_wb_dout1", 32'(d1_0), 32'h1234);
        chk("post_wb_busy_a", 32'(ba0), 32'h0);

        // Random stimulus against the reference model
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 39) == 0);
            RegWrite = 1'($urandom_range(0, 1));
            iss_en   = 1'($urandom_range(0, 1));
            adr_w    = 3'($urandom_range(0, 7));
            adr_i    = ($urandom_range(0, 3) == 0) ? adr_w : 3'($urandom_range(0, 7));
            adr_a    = ($urandom_range(0, 2) == 0) ? adr_w : 3'($urandom_range(0, 7));
            adr_b    = 3'($urandom_range(0, 7));
            Din      = 16'($urandom);
            #1;
            check_live("rnd_pre");
            tick();
            check_live("rnd_post");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
